// File: rtl/vga_sprite_overlay.sv
// vga_sprite_overlay: places a PIC_W x PIC_H ROM image at a movable position on
// the active display, steered by PS/2 make codes applied at frame boundaries.
// Three-stage pipeline from pixel coordinate to registered colour.
// Ports:
//   CLK, RST                   pixel clock, synchronous active-high reset
//   key_valid_i, key_code_i    PS/2 make-code strobe and code
//   frame_start_i              one-cycle pulse at start of vertical blanking
//   Ready_Sig                  active-display qualifier
//   Column_Addr_Sig/Row_Addr_Sig  current pixel coordinate
//   rom_addr_o, rom_data_i     external synchronous image ROM (1-cycle read)
//   key_en_i, key_color_i      transparent colour key
//   bg_color_i                 colour outside the image and for keyed pixels
//   Red_Sig/Green_Sig/Blue_Sig registered colour output
//   is_pic_o                   output pixel is an opaque image pixel
//   pos_x_o/pos_y_o            current top-left image position
module vga_sprite_overlay #(
    parameter int unsigned H_DATA = 1440,
    parameter int unsigned V_DATA = 900,
    parameter int unsigned PIC_W  = 256,
    parameter int unsigned PIC_H  = 256,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CH_W   = 1,
    parameter int unsigned STEP   = 20,
    parameter int unsigned X0     = 400,
    parameter int unsigned Y0     = 400
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              key_valid_i,
    input  logic [7:0]        key_code_i,
    input  logic              frame_start_i,
    input  logic              Ready_Sig,
    input  logic [10:0]       Column_Addr_Sig,
    input  logic [10:0]       Row_Addr_Sig,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [3*CH_W-1:0] rom_data_i,
    input  logic              key_en_i,
    input  logic [3*CH_W-1:0] key_color_i,
    input  logic [3*CH_W-1:0] bg_color_i,
    output logic [CH_W-1:0]   Red_Sig,
    output logic [CH_W-1:0]   Green_Sig,
    output logic [CH_W-1:0]   Blue_Sig,
    output logic              is_pic_o,
    output logic [10:0]       pos_x_o,
    output logic [10:0]       pos_y_o
);

    localparam int unsigned PIX_W = 3 * CH_W;
    localparam int unsigned SHIFT = $clog2(PIC_W);

    localparam logic signed [11:0] X_MAX  = 12'(H_DATA - PIC_W);
    localparam logic signed [11:0] Y_MAX  = 12'(V_DATA - PIC_H);
    localparam logic signed [11:0] STEP_V = 12'(STEP);
    localparam logic [11:0]        PIC_WV = 12'(PIC_W);
    localparam logic [11:0]        PIC_HV = 12'(PIC_H);

    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;

    typedef enum logic [2:0] {
        MV_NONE  = 3'd0,
        MV_LEFT  = 3'd1,
        MV_RIGHT = 3'd2,
        MV_UP    = 3'd3,
        MV_DOWN  = 3'd4
    } move_e;

    move_e             move_d, move_q, key_move_c;
    logic [10:0]       pos_x_d, pos_x_q, pos_y_d, pos_y_q;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              win_d1_d, win_d1_q, ready_d1_d, ready_d1_q;
    logic              win_d2_d, win_d2_q, ready_d2_d, ready_d2_q;
    logic [PIX_W-1:0]  rgb_d, rgb_q;
    logic              is_pic_d, is_pic_q;

    logic signed [11:0] x_sub_c, x_add_c, y_sub_c, y_add_c;
    logic [11:0]        col_c, row_c, px_c, py_c, dx_c, dy_c;
    logic               win_c, key_hit_c, opaque_c;

    // Decode make code into a move; unrecognised codes map to none.
    always_comb begin
        key_move_c = MV_NONE;
        case (key_code_i)
            CODE_LEFT:  key_move_c = MV_LEFT;
            CODE_RIGHT: key_move_c = MV_RIGHT;
            CODE_UP:    key_move_c = MV_UP;
            CODE_DOWN:  key_move_c = MV_DOWN;
            default:    key_move_c = MV_NONE;
        endcase
    end

    // Pending move: a new key beats the frame-start clear, so a key coincident
    // with frame_start_i survives into the next frame.
    always_comb begin
        move_d = move_q;
        if (frame_start_i) begin
            move_d = MV_NONE;
        end
        if (key_valid_i && (key_move_c != MV_NONE)) begin
            move_d = key_move_c;
        end
    end

    // Position update with saturation, evaluated in 12-bit signed arithmetic.
    always_comb begin
        x_sub_c = $signed({1'b0, pos_x_q}) - STEP_V;
        x_add_c = $signed({1'b0, pos_x_q}) + STEP_V;
        y_sub_c = $signed({1'b0, pos_y_q}) - STEP_V;
        y_add_c = $signed({1'b0, pos_y_q}) + STEP_V;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (frame_start_i) begin
            case (move_q)
                MV_LEFT:  pos_x_d = x_sub_c[11] ? 11'd0 : x_sub_c[10:0];
                MV_RIGHT: pos_x_d = (x_add_c > X_MAX) ? X_MAX[10:0] : x_add_c[10:0];
                MV_UP:    pos_y_d = y_sub_c[11] ? 11'd0 : y_sub_c[10:0];
                MV_DOWN:  pos_y_d = (y_add_c > Y_MAX) ? Y_MAX[10:0] : y_add_c[10:0];
                default:  ;
            endcase
        end
    end

    // Stage 1: window test and image-relative ROM address.
    always_comb begin
        col_c = {1'b0, Column_Addr_Sig};
        row_c = {1'b0, Row_Addr_Sig};
        px_c  = {1'b0, pos_x_q};
        py_c  = {1'b0, pos_y_q};
        dx_c  = col_c - px_c;
        dy_c  = row_c - py_c;
        win_c = Ready_Sig
              && (col_c >= px_c) && (col_c < (px_c + PIC_WV))
              && (row_c >= py_c) && (row_c < (py_c + PIC_HV));
        rom_addr_d = win_c ? ((ADDR_W'(dy_c) << SHIFT) + ADDR_W'(dx_c)) : '0;
        win_d1_d   = win_c;
        ready_d1_d = Ready_Sig;
    end

    // Stage 2 flags track the ROM read; stage 3 selects the colour.
    always_comb begin
        win_d2_d   = win_d1_q;
        ready_d2_d = ready_d1_q;
        key_hit_c  = key_en_i && (rom_data_i == key_color_i);
        opaque_c   = win_d2_q && !key_hit_c;
        rgb_d      = '0;
        if (ready_d2_q) begin
            rgb_d = opaque_c ? rom_data_i : bg_color_i;
        end
        is_pic_d = opaque_c;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            move_q     <= MV_NONE;
            pos_x_q    <= 11'(X0);
            pos_y_q    <= 11'(Y0);
            rom_addr_q <= '0;
            win_d1_q   <= 1'b0;
            ready_d1_q <= 1'b0;
            win_d2_q   <= 1'b0;
            ready_d2_q <= 1'b0;
            rgb_q      <= '0;
            is_pic_q   <= 1'b0;
        end else begin
            move_q     <= move_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            rom_addr_q <= rom_addr_d;
            win_d1_q   <= win_d1_d;
            ready_d1_q <= ready_d1_d;
            win_d2_q   <= win_d2_d;
            ready_d2_q <= ready_d2_d;
            rgb_q      <= rgb_d;
            is_pic_q   <= is_pic_d;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign Red_Sig    = rgb_q[PIX_W-1 -: CH_W];
    assign Green_Sig  = rgb_q[2*CH_W-1 -: CH_W];
    assign Blue_Sig   = rgb_q[CH_W-1:0];
    assign is_pic_o   = is_pic_q;
    assign pos_x_o    = pos_x_q;
    assign pos_y_o    = pos_y_q;

endmodule
